// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake, and hands {instr, pc+4} to decode through an IF/ID register
// backed by a one-entry skid buffer. Redirects squash in-flight fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] fetch_addr;
    logic        squash;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc_plus4;
    logic [31:0] wait_cnt;
    logic        ack_in_req;
    logic        accept;
    logic        consume;
    logic        skid_full_next;
    logic        new_req;
    logic [31:0] fetch_pc_plus4;

    assign imem_req       = (state == REQ);
    assign imem_addr      = fetch_addr;
    assign fetch_pc_plus4 = fetch_addr + 32'd4;

    // Handshake qualifiers, skid occupancy after this edge, and next FSM state
    always_comb begin
        state_next     = state;
        ack_in_req     = (state == REQ) && imem_ack;
        accept         = ack_in_req && !squash && !redirect_valid;
        consume        = id_valid && !stall;
        skid_full_next = 1'b0;
        pc_next        = pc;
        if (redirect_valid) begin
            skid_full_next = 1'b0;
        end else if (consume) begin
            skid_full_next = skid_valid && accept;
        end else begin
            skid_full_next = skid_valid || (accept && id_valid);
        end
        if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            pc_next = pc + 32'd4;
        end
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (accept && skid_full_next) begin
                    state_next = HOLD;
                end else begin
                    state_next = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid || !skid_valid) begin
                    state_next = REQ;
                end else begin
                    state_next = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
        new_req = (state_next == REQ) && ((state != REQ) || imem_ack);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC, latched request address and squash flag for a redirected in-flight fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            squash     <= 1'b0;
        end else begin
            pc <= pc_next;
            if (new_req) begin
                fetch_addr <= pc_next;
            end
            if (redirect_valid) begin
                squash <= (state == REQ) && !imem_ack;
            end else if (ack_in_req) begin
                squash <= 1'b0;
            end
        end
    end

    // IF/ID register and skid buffer: skid drains first, new data fills whichever is free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid      <= 1'b0;
            id_instr      <= 32'd0;
            id_pc_plus4   <= 32'd0;
            skid_valid    <= 1'b0;
            skid_instr    <= 32'd0;
            skid_pc_plus4 <= 32'd0;
        end else if (redirect_valid) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume) begin
            if (skid_valid) begin
                id_instr    <= skid_instr;
                id_pc_plus4 <= skid_pc_plus4;
                skid_valid  <= accept;
                if (accept) begin
                    skid_instr    <= imem_rdata;
                    skid_pc_plus4 <= fetch_pc_plus4;
                end
            end else if (accept) begin
                id_instr    <= imem_rdata;
                id_pc_plus4 <= fetch_pc_plus4;
            end else begin
                id_valid <= 1'b0;
            end
        end else if (!id_valid) begin
            if (accept) begin
                id_valid    <= 1'b1;
                id_instr    <= imem_rdata;
                id_pc_plus4 <= fetch_pc_plus4;
            end
        end else if (accept) begin
            skid_valid    <= 1'b1;
            skid_instr    <= imem_rdata;
            skid_pc_plus4 <= fetch_pc_plus4;
        end
    end

    // Watchdog on imem_ack; fetch_err stays set until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= 32'd0;
            fetch_err <= 1'b0;
        end else if (redirect_valid || ack_in_req) begin
            wait_cnt <= 32'd0;
        end else if (state == REQ) begin
            if (wait_cnt != 32'hFFFF_FFFF) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if ((TIMEOUT != 0) && ((wait_cnt + 32'd1) >= 32'(TIMEOUT))) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        fetch_err;

    int checks;
    int errors;

    localparam logic [31:0] A0 = 32'h0040_0000;

    fetch_unit #(.RESET_PC(A0), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_err      (fetch_err)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h8C5A_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ack_with(input logic [31:0] a);
        imem_ack   = 1'b1;
        imem_rdata = instr_of(a);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall          = 1'b0;

        // reset values
        #12;
        check("rst_req",    {31'd0, imem_req},  32'd0);
        check("rst_valid",  {31'd0, id_valid},  32'd0);
        check("rst_instr",  id_instr,           32'd0);
        check("rst_pc4",    id_pc_plus4,        32'd0);
        check("rst_err",    {31'd0, fetch_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // zero-wait memory, no stall
        for (int k = 0; k < 4; k++) begin
            check("zw_req",  {31'd0, imem_req}, 32'd1);
            check("zw_addr", imem_addr, A0 + 32'(4 * k));
            if (k > 0) begin
                check("zw_valid", {31'd0, id_valid}, 32'd1);
                check("zw_pc4",   id_pc_plus4, A0 + 32'(4 * k));
                check("zw_instr", id_instr, instr_of(A0 + 32'(4 * k - 4)));
            end
            ack_with(A0 + 32'(4 * k));
            tick();
        end
        check("zw_addr4", imem_addr,   32'h0040_0010);
        check("zw_pc4_4", id_pc_plus4, 32'h0040_0010);

        // stall for 4 cycles: ack of 00400010 goes to skid, request drops
        stall = 1'b1;
        ack_with(32'h0040_0010);
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("st_req",   {31'd0, imem_req}, 32'd0);
            check("st_pc4",   id_pc_plus4, 32'h0040_0010);
            check("st_instr", id_instr, instr_of(32'h0040_000C));
            check("st_valid", {31'd0, id_valid}, 32'd1);
            tick();
        end
        check("st_req4", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        check("st_skid_pc4",   id_pc_plus4, 32'h0040_0014);
        check("st_skid_instr", id_instr, instr_of(32'h0040_0010));
        check("st_skid_valid", {31'd0, id_valid}, 32'd1);
        tick();
        check("st_resume_req",  {31'd0, imem_req}, 32'd1);
        check("st_resume_addr", imem_addr, 32'h0040_0014);
        check("st_drained",     {31'd0, id_valid}, 32'd0);

        // three wait states before ack
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ws_req",   {31'd0, imem_req}, 32'd1);
            check("ws_addr",  imem_addr, 32'h0040_0014);
            check("ws_valid", {31'd0, id_valid}, 32'd0);
        end
        ack_with(32'h0040_0014);
        tick();
        imem_ack = 1'b0;
        check("ws_valid1", {31'd0, id_valid}, 32'd1);
        check("ws_pc4",    id_pc_plus4, 32'h0040_0018);
        check("ws_addr2",  imem_addr, 32'h0040_0018);
        tick();
        check("ws_valid0", {31'd0, id_valid}, 32'd0);

        // redirect while fetch of 00400018 is outstanding
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        tick();
        redirect_valid = 1'b0;
        check("rd_hold_addr", imem_addr, 32'h0040_0018);
        check("rd_hold_req",  {31'd0, imem_req}, 32'd1);
        ack_with(32'h0040_0018);
        tick();
        imem_ack = 1'b0;
        check("rd_discard_valid", {31'd0, id_valid}, 32'd0);
        check("rd_new_addr",      imem_addr, 32'h0040_0100);
        tick();
        check("rd_wait_valid", {31'd0, id_valid}, 32'd0);
        ack_with(32'h0040_0100);
        tick();
        imem_ack = 1'b0;
        check("rd_valid", {31'd0, id_valid}, 32'd1);
        check("rd_pc4",   id_pc_plus4, 32'h0040_0104);
        check("rd_instr", id_instr, instr_of(32'h0040_0100));

        // redirect coinciding with ack: ack discarded
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0200;
        ack_with(32'h0040_0104);
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        check("rdack_valid", {31'd0, id_valid}, 32'd0);
        check("rdack_addr",  imem_addr, 32'h0040_0200);

        // watchdog: no ack for 16 REQ cycles
        for (int k = 0; k < 15; k++) begin
            tick();
        end
        check("wd_err0", {31'd0, fetch_err}, 32'd0);
        tick();
        check("wd_err1", {31'd0, fetch_err}, 32'd1);
        check("wd_req",  {31'd0, imem_req}, 32'd1);
        check("wd_addr", imem_addr, 32'h0040_0200);
        tick();
        check("wd_sticky", {31'd0, fetch_err}, 32'd1);

        // mid-operation reset with a pending ack
        #2;
        rst_n = 1'b0;
        ack_with(32'h0040_0200);
        #1;
        check("mr_err",   {31'd0, fetch_err}, 32'd0);
        check("mr_req",   {31'd0, imem_req}, 32'd0);
        check("mr_valid", {31'd0, id_valid}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check("mr_addr",   imem_addr, A0);
        check("mr_req1",   {31'd0, imem_req}, 32'd1);
        check("mr_ignore", {31'd0, id_valid}, 32'd0);

        // PC wrap via redirect to FFFFFFFF (coinciding with ack)
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        ack_with(A0);
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        ack_with(32'hFFFF_FFFC);
        tick();
        imem_ack = 1'b0;
        check("wrap_next",  imem_addr, 32'h0000_0000);
        check("wrap_pc4",   id_pc_plus4, 32'h0000_0000);
        check("wrap_valid", {31'd0, id_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
